ifetch: RTL

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ifetch.sv
// Instruction fetch: issues in-order imem requests under a 2-slot credit and
// buffers {pc, instr} pairs for decode; redirects flush and drain in-flight responses.
module ifetch #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h8000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   if_valid_o,
    output logic [INSTR_WIDTH-1:0] if_instr_o,
    output logic [PC_WIDTH-1:0]    if_pc_o,
    input  logic                   id_ready_i,
    output logic [1:0]             dbg_state_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PC_WIDTH-1:0]    r_fetch_pc;
    logic [PC_WIDTH-1:0]    r_oq_addr [2];
    logic [1:0]             r_oq_cnt;
    logic [PC_WIDTH-1:0]    r_f_pc [2];
    logic [INSTR_WIDTH-1:0] r_f_instr [2];
    logic [1:0]             r_f_cnt;
    logic [1:0]             r_disc;
    logic [1:0]             w_disc_nxt;

    logic                   w_redirect;
    logic                   w_credit;
    logic                   w_req;
    logic                   w_xfer;
    logic                   w_resp;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_unused;

    // Credit counts both in-flight requests and buffered pairs, so a response
    // always has a FIFO slot waiting for it.
    assign w_redirect = redirect_i && (r_state != ST_BOOT);
    assign w_credit   = ({1'b0, r_oq_cnt} + {1'b0, r_f_cnt}) < 3'd2;
    assign w_req      = (r_state == ST_RUN) && !redirect_i && w_credit;
    assign w_xfer     = w_req && imem_gnt_i;
    assign w_resp     = imem_rvalid_i && (r_state == ST_RUN) && (r_oq_cnt != 2'd0);
    assign w_push     = w_resp && !w_redirect;
    assign w_pop      = (r_f_cnt != 2'd0) && id_ready_i && !w_redirect;
    assign w_drop     = imem_rvalid_i && (r_state == ST_DRAIN) && (r_disc != 2'd0);
    assign w_unused   = &{1'b0, redirect_pc_i[1:0]};

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;
    assign if_valid_o  = (r_f_cnt != 2'd0);
    assign if_instr_o  = if_valid_o ? r_f_instr[0] : NOP;
    assign if_pc_o     = if_valid_o ? r_f_pc[0] : '0;
    assign dbg_state_o = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_disc_nxt  = r_disc;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                // A response landing in the redirect cycle is dropped directly,
                // so it is not counted again in the discard budget.
                if (w_redirect) begin
                    w_disc_nxt  = r_oq_cnt - {1'b0, w_resp};
                    w_state_nxt = (w_disc_nxt != 2'd0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_drop) begin
                    w_disc_nxt = r_disc - 2'd1;
                end
                if (w_disc_nxt == 2'd0) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_disc  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_disc  <= w_disc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_fetch_pc <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
        end else if (w_xfer) begin
            r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
        end
    end

    // Outstanding-address queue; head is always entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oq_cnt     <= 2'd0;
            r_oq_addr[0] <= '0;
            r_oq_addr[1] <= '0;
        end else if (w_redirect) begin
            r_oq_cnt <= 2'd0;
        end else begin
            case ({w_xfer, w_resp})
                2'b10: begin
                    r_oq_addr[r_oq_cnt[0]] <= r_fetch_pc;
                    r_oq_cnt               <= r_oq_cnt + 2'd1;
                end
                2'b01: begin
                    r_oq_addr[0] <= r_oq_addr[1];
                    r_oq_cnt     <= r_oq_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_oq_cnt == 2'd2) begin
                        r_oq_addr[0] <= r_oq_addr[1];
                        r_oq_addr[1] <= r_fetch_pc;
                    end else begin
                        r_oq_addr[0] <= r_fetch_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output FIFO of {pc, instr}; head is always entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_cnt      <= 2'd0;
            r_f_pc[0]    <= '0;
            r_f_pc[1]    <= '0;
            r_f_instr[0] <= '0;
            r_f_instr[1] <= '0;
        end else if (w_redirect) begin
            r_f_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_f_pc[r_f_cnt[0]]    <= r_oq_addr[0];
                    r_f_instr[r_f_cnt[0]] <= imem_rdata_i;
                    r_f_cnt               <= r_f_cnt + 2'd1;
                end
                2'b01: begin
                    r_f_pc[0]    <= r_f_pc[1];
                    r_f_instr[0] <= r_f_instr[1];
                    r_f_cnt      <= r_f_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_f_cnt == 2'd2) begin
                        r_f_pc[0]    <= r_f_pc[1];
                        r_f_instr[0] <= r_f_instr[1];
                        r_f_pc[1]    <= r_oq_addr[0];
                        r_f_instr[1] <= imem_rdata_i;
                    end else begin
                        r_f_pc[0]    <= r_oq_addr[0];
                        r_f_instr[0] <= imem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(imem_rvalid_i && (r_oq_cnt == 2'd0) && (r_disc == 2'd0)))
                else $warning("ifetch: imem_rvalid_i with no outstanding request ignored");
            assert (r_oq_cnt != 2'd3)
                else $error("ifetch: outstanding request count exceeded 2");
        end
    end

endmodule
